apb_master_mux: RTL

- Parametrised successor to the five-slave APB master used in the MCU.
- Bridges the CPU's simple transfer/ready bus to one APB3 master port.
- Slave count, address map and wait-state handling are generic.
- Adds PSLVERR propagation, decode-miss error response and an optional access timeout.
- Sits between the CPU core and the RAM, GPO, GPI, GPIO and FND peripherals.

---
 rtl/apb_pkg.sv | 37 +++
 rtl/apb_addr_decoder.sv | 25 ++
 rtl/apb_master_mux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and decode helpers for the parametrised APB master.
package apb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [DATA_W-1:0] wdata;
   } apb_req_t;

   // Index width for n slaves; never below one bit so single-slave builds stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic decode_hit(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input int unsigned       shift,
                                       input int unsigned       idxw,
                                       input int unsigned       nslv);
      logic              match;
      logic [ADDR_W-1:0] idx;
      match = (addr >> (shift + idxw)) == (base >> (shift + idxw));
      idx   = (addr >> shift) & ((ADDR_W'(1) << idxw) - ADDR_W'(1));
      return match && (idx < nslv);
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: byte address to one-hot slave select and hit flag.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int unsigned       NUM_SLV   = 5,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned       SLV_SHIFT = 12
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [NUM_SLV-1:0] sel_c,
   output logic               hit_c
);

   localparam int unsigned IDXW = idx_width(NUM_SLV);

   logic [IDXW-1:0] idx;

   assign idx   = IDXW'(addr >> SLV_SHIFT);
   assign hit_c = decode_hit(addr, BASE_ADDR, SLV_SHIFT, IDXW, NUM_SLV);

   for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
      assign sel_c[i] = hit_c && (32'(idx) == i);
   end

endmodule

// File: rtl/apb_master_mux.sv
// CPU transfer/ready bus to APB3 master bridge with generic slave map.
// Optional access timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_mux
   import apb_pkg::*;
#(
   parameter int unsigned       NUM_SLV     = 5,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned       SLV_SHIFT   = 12,
   parameter int unsigned       TIMEOUT_CYC = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      transfer,
   input  logic                      write,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata,
   output logic                      ready,
   output logic                      err,
   output logic [ADDR_W-1:0]         PADDR,
   output logic                      PWRITE,
   output logic                      PENABLE,
   output logic [DATA_W-1:0]         PWDATA,
   output logic [NUM_SLV-1:0]        PSEL,
   input  logic [DATA_W*NUM_SLV-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR
);

   apb_state_e           state_q, state_d;
   apb_req_t             req_q, req_d;
   logic [NUM_SLV-1:0]   psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 ready_q, ready_d;
   logic                 err_q, err_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;

   logic [NUM_SLV-1:0]   dec_sel_c;
   logic                 dec_hit_c;
   logic [DATA_W-1:0]    prdata_sel;
   logic                 pready_sel;
   logic                 pslverr_sel;
   logic                 tmo_exp_c;

   apb_addr_decoder #(
      .NUM_SLV   (NUM_SLV),
      .BASE_ADDR (BASE_ADDR),
      .SLV_SHIFT (SLV_SHIFT)
   ) u_dec (
      .addr  (addr),
      .sel_c (dec_sel_c),
      .hit_c (dec_hit_c)
   );

   // PSEL doubles as the held select, so only the addressed slave's lines are seen.
   always_comb begin
      prdata_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (psel_q[i]) prdata_sel = prdata_sel | PRDATA[i*DATA_W +: DATA_W];
      end
      pready_sel  = |(PREADY & psel_q);
      pslverr_sel = |(PSLVERR & psel_q);
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TMO_W = idx_width(TIMEOUT_CYC);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   assign tmo_exp_c = (state_q == ACCESS) && !pready_sel &&
                      (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   // Cleared while in SETUP so it reads zero on the first ACCESS cycle.
   always_comb begin
      tmo_d = tmo_q;
      if (state_q == SETUP) tmo_d = '0;
      else if ((state_q == ACCESS) && !pready_sel) tmo_d = tmo_q + TMO_W'(1);
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYC;
   assign tmo_exp_c      = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      ready_d   = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               if (dec_hit_c) begin
                  req_d   = '{addr: addr, write: write, wdata: wdata};
                  psel_d  = dec_sel_c;
                  state_d = SETUP;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  ready_d = 1'b1;
                  state_d = RESP;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready_sel || tmo_exp_c) begin
               rdata_d   = (pready_sel && !req_q.write) ? prdata_sel : '0;
               err_d     = pready_sel ? pslverr_sel : 1'b1;
               ready_d   = 1'b1;
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q   <= IDLE;
         req_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign PADDR   = req_q.addr;
   assign PWRITE  = req_q.write;
   assign PWDATA  = req_q.wdata;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign ready   = ready_q;
   assign err     = err_q;
   assign rdata   = rdata_q;

endmodule
